// File: rtl/spi_controller.sv
// Purpose : SPI mode-0 register-write controller; shifts one 16-bit frame {rw, addr[6:0], data[7:0]} MSB first.
// Latency : nCS falls 1 cycle after acceptance; done pulses 33*HALF_PERIOD+1 cycles after acceptance.
// Backpr. : req_ready is high only in IDLE; req_valid at any other time is ignored, and nothing is queued.
//
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake
//   req_rw/addr/data      frame fields, latched at acceptance
//   nCS, SCLK, copi       SPI pins (all registered)
//   busy                  high whenever the controller is not in IDLE
//   done                  one-cycle pulse when a frame completes
module spi_controller #(
    parameter int unsigned HALF_PERIOD = 2,
    parameter int unsigned GAP_CYCLES  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_data,
    output logic       nCS,
    output logic       SCLK,
    output logic       copi,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam logic [7:0] HP_LAST  = 8'(HALF_PERIOD - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

    state_t      state_q,   state_d;
    logic [7:0]  hp_cnt_q,  hp_cnt_d;
    logic        phase_q,   phase_d;     // 0: SCLK-low half of a bit, 1: SCLK-high half
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  gap_cnt_q, gap_cnt_d;
    logic [15:0] shreg_q,   shreg_d;     // top bit is the next bit to put on copi
    logic        ncs_q,     ncs_d;
    logic        sclk_q,    sclk_d;
    logic        copi_q,    copi_d;
    logic        busy_q,    busy_d;
    logic        done_q,    done_d;
    logic        ready_q,   ready_d;

    logic        hp_last;
    logic [15:0] frame;

    assign hp_last = (hp_cnt_q == HP_LAST);
    assign frame   = {req_rw, req_addr, req_data};

    always_comb begin
        state_d   = state_q;
        hp_cnt_d  = hp_cnt_q;
        phase_d   = phase_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        shreg_d   = shreg_q;
        ncs_d     = ncs_q;
        sclk_d    = sclk_q;
        copi_d    = copi_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ready_d   = ready_q;

        unique case (state_q)
            IDLE: begin
                // Acceptance is keyed on the state rather than on ready_q so
                // that a request can already be taken on the first edge after
                // reset release.
                if (req_valid) begin
                    state_d   = SHIFT;
                    shreg_d   = {frame[14:0], 1'b0};
                    copi_d    = frame[15];
                    ncs_d     = 1'b0;
                    sclk_d    = 1'b0;
                    hp_cnt_d  = 8'd0;
                    phase_d   = 1'b0;
                    bit_cnt_d = 4'd0;
                    busy_d    = 1'b1;
                    ready_d   = 1'b0;
                end else begin
                    ready_d   = 1'b1;
                    busy_d    = 1'b0;
                end
            end

            SHIFT: begin
                if (hp_last) begin
                    hp_cnt_d = 8'd0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                        sclk_d  = 1'b1;
                    end else begin
                        // End of a bit: SCLK falls and copi moves to the next
                        // bit in the same cycle, so copi only changes while
                        // SCLK is low. The 15->0 rollover ends the frame and
                        // copi keeps the last bit through HOLD.
                        phase_d   = 1'b0;
                        sclk_d    = 1'b0;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd15) begin
                            state_d = HOLD;
                        end else begin
                            copi_d  = shreg_q[15];
                            shreg_d = {shreg_q[14:0], 1'b0};
                        end
                    end
                end else begin
                    hp_cnt_d = hp_cnt_q + 8'd1;
                end
            end

            HOLD: begin
                if (hp_last) begin
                    hp_cnt_d  = 8'd0;
                    state_d   = GAP;
                    ncs_d     = 1'b1;
                    copi_d    = 1'b0;
                    done_d    = 1'b1;
                    gap_cnt_d = 8'd0;
                end else begin
                    hp_cnt_d = hp_cnt_q + 8'd1;
                end
            end

            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = 8'd0;
                    state_d   = IDLE;
                    ready_d   = 1'b1;
                    busy_d    = 1'b0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            hp_cnt_q  <= 8'd0;
            phase_q   <= 1'b0;
            bit_cnt_q <= 4'd0;
            gap_cnt_q <= 8'd0;
            shreg_q   <= 16'd0;
            ncs_q     <= 1'b1;
            sclk_q    <= 1'b0;
            copi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            hp_cnt_q  <= hp_cnt_d;
            phase_q   <= phase_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            shreg_q   <= shreg_d;
            ncs_q     <= ncs_d;
            sclk_q    <= sclk_d;
            copi_q    <= copi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
        end
    end

    assign nCS       = ncs_q;
    assign SCLK      = sclk_q;
    assign copi      = copi_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign req_ready = ready_q;

endmodule

// File: tb/tb_spi_controller.sv
// Purpose : directed bench for spi_controller (default timing instance plus a HALF_PERIOD=1 instance).
// Latency : expected cycle offsets are measured from the acceptance cycle T.
// Backpr. : requests are held until req_ready is seen; every wait is bounded.
module tb_spi_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    always #5 clk = ~clk;

    // default instance
    logic       req_valid = 1'b0;
    logic       req_rw = 1'b0;
    logic [6:0] req_addr = 7'd0;
    logic [7:0] req_data = 8'd0;
    logic       req_ready, nCS, SCLK, copi, busy, done;

    // HALF_PERIOD = 1, GAP_CYCLES = 1 instance
    logic       v1 = 1'b0;
    logic       rw1 = 1'b0;
    logic [6:0] a1 = 7'd0;
    logic [7:0] d1 = 8'd0;
    logic       ready1, ncs1, sclk1, copi1, busy1, done1;

    spi_controller dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rw    (req_rw),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .nCS       (nCS),
        .SCLK      (SCLK),
        .copi      (copi),
        .busy      (busy),
        .done      (done)
    );

    spi_controller #(.HALF_PERIOD(1), .GAP_CYCLES(1)) dut_hp1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (v1),
        .req_ready (ready1),
        .req_rw    (rw1),
        .req_addr  (a1),
        .req_data  (d1),
        .nCS       (ncs1),
        .SCLK      (sclk1),
        .copi      (copi1),
        .busy      (busy1),
        .done      (done1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // pin monitor, default instance (sampled on the falling edge)
    int          rises = 0, frame_rises = 0, first_rise = 0, ncs_fall = 0, nfalls = 0;
    int          done_cnt = 0, done_cyc = 0, ready_cyc = 0;
    int          high_run = 0, last_high_run = 0, edge_bad = 0, both_hi = 0;
    logic [15:0] rx = 16'd0;
    logic        p_sclk = 1'b0, p_ncs = 1'b1, p_ready = 1'b0;

    initial forever begin
        @(negedge clk);
        if (!nCS && p_ncs) begin
            ncs_fall      = cyc;
            frame_rises   = 0;
            nfalls++;
            last_high_run = high_run;
            high_run      = 0;
        end
        if (nCS) high_run++;
        if (SCLK && !p_sclk) begin
            rises++;
            frame_rises++;
            rx = {rx[14:0], copi};
            if (frame_rises == 1) first_rise = cyc;
        end
        if ((SCLK !== p_sclk) && nCS && p_ncs) edge_bad++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            if (req_ready) both_hi++;
        end
        if (req_ready && !p_ready) ready_cyc = cyc;
        p_sclk  = SCLK;
        p_ncs   = nCS;
        p_ready = req_ready;
    end

    // pin monitor, HALF_PERIOD = 1 instance
    int          rises1 = 0, toggles1 = 0, done_cnt1 = 0, done_cyc1 = 0, ready_cyc1 = 0;
    logic [15:0] rx1 = 16'd0;
    logic        p_sclk1 = 1'b0, p_ncs1 = 1'b1, p_ready1 = 1'b0;

    initial forever begin
        @(negedge clk);
        if (sclk1 && !p_sclk1) begin
            rises1++;
            rx1 = {rx1[14:0], copi1};
        end
        if ((sclk1 !== p_sclk1) && !ncs1 && !p_ncs1) toggles1++;
        if (done1) begin
            done_cnt1++;
            done_cyc1 = cyc;
        end
        if (ready1 && !p_ready1) ready_cyc1 = cyc;
        p_sclk1  = sclk1;
        p_ncs1   = ncs1;
        p_ready1 = ready1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic nedge();
        @(negedge clk);
        #1;
    endtask

    // Present a request and return the cycle T in which it is seen accepted.
    task automatic accept0(input logic rw, input logic [6:0] a, input logic [7:0] d,
                           output int t, output bit ok);
        @(posedge clk);
        #1;
        req_rw    = rw;
        req_addr  = a;
        req_data  = d;
        req_valid = 1'b1;
        ok = 1'b0;
        t  = 0;
        for (int i = 0; i < 200; i++) begin
            nedge();
            if (req_ready) begin
                ok = 1'b1;
                t  = cyc;
                break;
            end
        end
    endtask

    task automatic drop0();
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done0(input int base, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            nedge();
            if (done_cnt > base) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_ready0(output int t, output bit ok);
        ok = 1'b0;
        t  = 0;
        for (int i = 0; i < 50; i++) begin
            nedge();
            if (req_ready) begin
                ok = 1'b1;
                t  = cyc;
                break;
            end
        end
    endtask

    initial begin
        int t, t2, tr, d0, n0, r0, s1, tg1;
        bit ok;

        // reset state, mid-cycle
        #12;
        check("rst_ncs",   32'(nCS), 1);
        check("rst_sclk",  32'(SCLK), 0);
        check("rst_copi",  32'(copi), 0);
        check("rst_done",  32'(done), 0);
        check("rst_busy",  32'(busy), 0);
        check("rst_ready", 32'(req_ready), 0);
        check("rst_ncs1",  32'(ncs1), 1);
        @(negedge clk);
        rst_n = 1'b1;
        nedge();
        check("rel_ready",  32'(req_ready), 1);
        check("rel_busy",   32'(busy), 0);
        check("rel_ready1", 32'(ready1), 1);

        // default timing: rw=1 addr=0x00 data=0xFF
        d0 = done_cnt;
        accept0(1'b1, 7'h00, 8'hFF, t, ok);
        check("a_accept", 32'(ok), 1);
        drop0();
        nedge();
        check("a_t1_ncs",   32'(nCS), 0);
        check("a_t1_sclk",  32'(SCLK), 0);
        check("a_t1_copi",  32'(copi), 1);
        check("a_t1_busy",  32'(busy), 1);
        check("a_t1_ready", 32'(req_ready), 0);
        wait_done0(d0, ok);
        check("a_done_seen", 32'(ok), 1);
        wait_ready0(tr, ok);
        check("a_ready_seen", 32'(ok), 1);
        check("a_word",      32'(rx), 32'h80FF);
        check("a_rises",     32'(frame_rises), 16);
        check("a_ncs_fall",  32'(ncs_fall - t), 1);
        check("a_first_rise",32'(first_rise - t), 3);
        check("a_done_cyc",  32'(done_cyc - t), 67);
        check("a_ready_cyc", 32'(ready_cyc - t), 69);
        check("a_done_cnt",  32'(done_cnt - d0), 1);
        check("a_idle_busy", 32'(busy), 0);

        // frame latched at acceptance: inputs change at T+5
        d0 = done_cnt;
        accept0(1'b1, 7'h04, 8'h80, t, ok);
        check("b_accept", 32'(ok), 1);
        drop0();
        repeat (4) @(posedge clk);
        #1;
        req_data = 8'h3C;
        req_addr = 7'h7F;
        req_rw   = 1'b0;
        wait_done0(d0, ok);
        check("b_done_seen", 32'(ok), 1);
        wait_ready0(tr, ok);
        check("b_word", 32'(rx), 32'h8480);

        // back-to-back with req_valid held high
        d0 = done_cnt;
        accept0(1'b1, 7'h01, 8'h55, t, ok);
        check("c_accept1", 32'(ok), 1);
        @(posedge clk);
        #1;
        req_rw   = 1'b0;
        req_addr = 7'h02;
        req_data = 8'hAA;
        wait_done0(d0, ok);
        check("c_done1_seen", 32'(ok), 1);
        check("c_word1", 32'(rx), 32'h8155);
        wait_ready0(t2, ok);
        check("c_ready_seen", 32'(ok), 1);
        check("c_accept2_cyc", 32'(t2 - t), 69);
        drop0();
        wait_done0(d0 + 1, ok);
        check("c_done2_seen", 32'(ok), 1);
        check("c_word2",     32'(rx), 32'h02AA);
        check("c_ncs_high",  32'(last_high_run), 3);
        check("c_done_cnt",  32'(done_cnt - d0), 2);
        check("c_done2_cyc", 32'(done_cyc - t2), 67);
        wait_ready0(tr, ok);

        // req_valid pulsed during SHIFT is ignored
        d0 = done_cnt;
        n0 = nfalls;
        accept0(1'b1, 7'h2A, 8'hC3, t, ok);
        check("d_accept", 32'(ok), 1);
        drop0();
        repeat (10) @(posedge clk);
        #1;
        req_data  = 8'h00;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wait_done0(d0, ok);
        check("d_done_seen", 32'(ok), 1);
        wait_ready0(tr, ok);
        repeat (10) nedge();
        check("d_word",     32'(rx), 32'hAAC3);
        check("d_done_cnt", 32'(done_cnt - d0), 1);
        check("d_frames",   32'(nfalls - n0), 1);
        check("d_ready",    32'(req_ready), 1);

        // reset asserted at the 8th SCLK rise
        d0 = done_cnt;
        accept0(1'b1, 7'h33, 8'h5A, t, ok);
        check("e_accept", 32'(ok), 1);
        r0 = rises;
        drop0();
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            nedge();
            if (rises - r0 >= 8) begin
                ok = 1'b1;
                break;
            end
        end
        check("e_rise8_seen", 32'(ok), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("e_rst_ncs",   32'(nCS), 1);
        check("e_rst_sclk",  32'(SCLK), 0);
        check("e_rst_copi",  32'(copi), 0);
        check("e_rst_busy",  32'(busy), 0);
        check("e_rst_ready", 32'(req_ready), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        nedge();
        check("e_no_done", 32'(done_cnt - d0), 0);
        check("e_ready",   32'(req_ready), 1);
        accept0(1'b0, 7'h55, 8'h0F, t, ok);
        check("e_accept2", 32'(ok), 1);
        drop0();
        wait_done0(d0, ok);
        check("e_done_seen", 32'(ok), 1);
        check("e_word",     32'(rx), 32'h550F);
        check("e_rises",    32'(frame_rises), 16);
        check("e_done_cyc", 32'(done_cyc - t), 67);
        wait_ready0(tr, ok);

        // HALF_PERIOD = 1, GAP_CYCLES = 1
        s1 = toggles1;
        r0 = rises1;
        d0 = done_cnt1;
        @(posedge clk);
        #1;
        rw1 = 1'b1;
        a1  = 7'h12;
        d1  = 8'h34;
        v1  = 1'b1;
        ok  = 1'b0;
        tg1 = 0;
        for (int i = 0; i < 50; i++) begin
            nedge();
            if (ready1) begin
                ok  = 1'b1;
                tg1 = cyc;
                break;
            end
        end
        check("f_accept", 32'(ok), 1);
        @(posedge clk);
        #1;
        v1 = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            nedge();
            if (ready1 && done_cnt1 > d0) begin
                ok = 1'b1;
                break;
            end
        end
        check("f_ready_seen", 32'(ok), 1);
        check("f_word",      32'(rx1), 32'h9234);
        check("f_rises",     32'(rises1 - r0), 16);
        check("f_toggles",   32'(toggles1 - s1), 32);
        check("f_done_cyc",  32'(done_cyc1 - tg1), 34);
        check("f_ready_cyc", 32'(ready_cyc1 - tg1), 35);
        check("f_done_cnt",  32'(done_cnt1 - d0), 1);

        // global properties
        check("g_edge_ncs_high",  32'(edge_bad), 0);
        check("g_done_and_ready", 32'(both_hi), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_controller.md
SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 Parameter: HALF_PERIOD, default 2, SCLK half-period in clk cycles; legal range 1..255.
REQ-002 Parameter: GAP_CYCLES, default 2, minimum nCS-high time in clk cycles between frames; legal range 1..255.
REQ-003 clk  input  1  single system clock; all logic is clocked on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  controller can accept a request.
REQ-007 req_rw  input  1  frame bit 15 (1 = write).
REQ-008 req_addr  input  7  register address.
REQ-009 req_data  input  8  register data.
REQ-010 nCS  output  1  active-low chip select.
REQ-011 SCLK  output  1  serial clock, idles low.
REQ-012 copi  output  1  serial data, controller to peripheral.
REQ-013 busy  output  1  high whenever the state is not IDLE.
REQ-014 done  output  1  one-cycle pulse at frame completion.

Function
REQ-015 Protocol: SPI mode 0, 16-bit frame, MSB first.
- Frame = {req_rw, req_addr[6:0], req_data[7:0]}.
- The peripheral samples copi on SCLK rising edges.
- copi changes only while SCLK is low.

REQ-016 States: IDLE, SHIFT, HOLD, GAP. All outputs are registered.

REQ-017 Handshake:
- req_ready = 1 only in IDLE.
- A request is accepted on a cycle with req_valid && req_ready.
- The frame is latched at acceptance. Input changes after acceptance have no effect on the frame in flight.

REQ-018 Acceptance at cycle T:
- At T+1: state = SHIFT, nCS = 0, SCLK = 0, copi = frame[15].

REQ-019 Bit timing in SHIFT:
- Bit k (k = 0..15) occupies 2*HALF_PERIOD cycles.
- SCLK is low for the first HALF_PERIOD cycles and high for the second HALF_PERIOD cycles.
- Bit k starts at T+1+2*HALF_PERIOD*k.
- copi = frame[15-k] for the whole bit period.

REQ-020 Edge count: exactly 16 SCLK rising edges per frame; no SCLK edges occur while nCS = 1.

REQ-021 After bit 15 (at T+1+32*HALF_PERIOD):
- State = HOLD, SCLK = 0, nCS = 0.
- copi holds frame[0].
- HOLD lasts HALF_PERIOD cycles.

REQ-022 Exiting HOLD (at T+1+33*HALF_PERIOD):
- nCS = 1, copi = 0, done = 1 for exactly one cycle.
- State = GAP for GAP_CYCLES cycles.

REQ-023 Return to IDLE at T+1+33*HALF_PERIOD+GAP_CYCLES; req_ready = 1 from that cycle.

REQ-024 Back-to-back requests:
- A request held valid is accepted on the first IDLE cycle.
- The minimum nCS-high time is therefore GAP_CYCLES+1 cycles.

REQ-025 req_valid outside IDLE is ignored: no queuing and no side effects.

REQ-026 Counters:
- The half-period counter wraps from HALF_PERIOD-1 to 0.
- The bit counter is 4 bits wide. Its 15→0 rollover is the exit from SHIFT; it never wraps inside a frame.

REQ-027 done and req_ready are never high in the same cycle.

Reset
REQ-028 While rst_n = 0, the following outputs hold immediately, independent of clk:
- nCS = 1, SCLK = 0, copi = 0.
- done = 0, busy = 0, req_ready = 0.
- State = IDLE and all counters = 0.

REQ-029 After rst_n rises:
- req_ready = 1 from the first clk rising edge.
- The first request can be accepted on that edge.

REQ-030 Reset during a frame:
- The frame is aborted and done does not pulse.
- After release, the next frame starts cleanly with no residual SCLK edges.

Verification
REQ-031 Defaults (HALF_PERIOD = 2, GAP_CYCLES = 2), rw = 1, addr = 0x00, data = 0xFF, accepted at T:
- copi bit sequence is 1000_0000_1111_1111.
- nCS falls at T+1.
- First SCLK rise at T+3.
- done pulses at T+67.
- req_ready returns at T+69.

REQ-032 rw = 1, addr = 0x04, data = 0x80, with req_data changed at T+5:
- The received word is 0x8480.

REQ-033 req_valid held high for two requests (0x01/0x55 then 0x02/0xAA):
- Two frames are sent.
- nCS is high for exactly 3 cycles between them.
- done pulses twice.

REQ-034 req_valid pulsed during SHIFT:
- Ignored; exactly one frame and one done pulse result.

REQ-035 rst_n asserted at the 8th SCLK rise:
- nCS = 1 and SCLK = 0 without waiting for a clk edge.
- No done pulse.
- A new request after release produces a correct full 16-bit frame.

REQ-036 HALF_PERIOD = 1:
- SCLK toggles every cycle during SHIFT.
- The frame occupies 32 cycles.
- done pulses at T+34.
